// File: rtl/oc_guard.sv
// oc_guard: per-channel overcurrent sense qualifier that drops H-bridge enables on a fault.
// Define OC_AUTO_RETRY_EN to add bounded TRIP->COOL auto-recovery and the locked flag.
module oc_guard #(
   parameter int N_CH         = 2,
   parameter int QUAL_CYCLES  = 33554432,
   parameter int RETRY_CYCLES = 50000000,
   parameter int MAX_RETRIES  = 3,
   parameter bit LINKED       = 1'b1
) (
   input  logic            CLK100MHZ,
   input  logic            RST,
   input  logic [N_CH-1:0] oc_n,
   input  logic [N_CH-1:0] clr,
   output logic [N_CH-1:0] en,
   output logic [N_CH-1:0] fault,
   output logic [N_CH-1:0] locked,
   output logic            overcurrent
);

   typedef enum logic [1:0] {ST_IDLE, ST_QUAL, ST_TRIP, ST_COOL} state_t;

   localparam int QW = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;
`ifdef OC_AUTO_RETRY_EN
   localparam int RW  = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
   localparam int CW  = (QW > RW) ? QW : RW;
   localparam int RCW = $clog2(MAX_RETRIES + 1);
   localparam logic [CW-1:0]  RETRY_LAST = CW'(RETRY_CYCLES - 1);
   localparam logic [RW-1:0]  IDLE_LAST  = RW'(RETRY_CYCLES - 1);
   localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRIES);
`else
   localparam int CW = QW;
`endif
   localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL_CYCLES - 1);

   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;
   logic [N_CH-1:0] w_s;
   state_t          r_state     [N_CH];
   state_t          w_state_nxt [N_CH];
   logic [CW-1:0]   r_cnt       [N_CH];
   logic [CW-1:0]   w_cnt_nxt   [N_CH];
   logic [N_CH-1:0] w_faulted_nxt;
`ifdef OC_AUTO_RETRY_EN
   logic [RCW-1:0]  r_retry     [N_CH];
   logic [RCW-1:0]  w_retry_nxt [N_CH];
   logic [RW-1:0]   r_idle      [N_CH];
   logic [RW-1:0]   w_idle_nxt  [N_CH];
   logic [N_CH-1:0] w_locked_nxt;
   logic [N_CH-1:0] r_locked;
`endif

   // Sense pins are asynchronous; reset to 1 so a reset never looks like a fault.
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= oc_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = ~r_sync2;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
`ifdef OC_AUTO_RETRY_EN
         w_retry_nxt[i] = r_retry[i];
         w_idle_nxt[i]  = '0;
         if (clr[i] && (r_state[i] != ST_TRIP)) begin
            w_retry_nxt[i] = '0;
         end
`endif
         case (r_state[i])
            ST_IDLE: begin
               if (w_s[i]) begin
                  w_state_nxt[i] = ST_QUAL;
                  w_cnt_nxt[i]   = '0;
               end
`ifdef OC_AUTO_RETRY_EN
               else if (r_idle[i] == IDLE_LAST) begin
                  w_retry_nxt[i] = '0;
               end else begin
                  w_idle_nxt[i] = r_idle[i] + RW'(1);
               end
`endif
            end
            // Only the sense level at the end of the window decides the outcome.
            ST_QUAL: begin
               if (r_cnt[i] == QUAL_LAST) begin
                  w_state_nxt[i] = w_s[i] ? ST_TRIP : ST_IDLE;
                  w_cnt_nxt[i]   = '0;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CW'(1);
               end
            end
            ST_TRIP: begin
               if (clr[i] && !w_s[i]) begin
                  w_state_nxt[i] = ST_IDLE;
`ifdef OC_AUTO_RETRY_EN
                  w_retry_nxt[i] = '0;
`endif
               end
`ifdef OC_AUTO_RETRY_EN
               else if (r_retry[i] < RETRY_MAX) begin
                  w_state_nxt[i] = ST_COOL;
                  w_cnt_nxt[i]   = '0;
                  w_retry_nxt[i] = r_retry[i] + RCW'(1);
               end
`endif
            end
            ST_COOL: begin
`ifdef OC_AUTO_RETRY_EN
               if (r_cnt[i] == RETRY_LAST) begin
                  w_state_nxt[i] = ST_IDLE;
                  w_cnt_nxt[i]   = '0;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CW'(1);
               end
`else
               w_state_nxt[i] = ST_IDLE;
`endif
            end
            default: w_state_nxt[i] = ST_IDLE;
         endcase
         w_faulted_nxt[i] = (w_state_nxt[i] == ST_TRIP) || (w_state_nxt[i] == ST_COOL);
`ifdef OC_AUTO_RETRY_EN
         w_locked_nxt[i] = (w_state_nxt[i] == ST_TRIP) && (w_retry_nxt[i] >= RETRY_MAX);
`endif
      end
   end

   // Outputs are registered from next-state so they change on the same edge as the FSM.
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
`ifdef OC_AUTO_RETRY_EN
            r_retry[i] <= '0;
            r_idle[i]  <= '0;
`endif
         end
         en          <= '1;
         fault       <= '0;
         overcurrent <= 1'b0;
`ifdef OC_AUTO_RETRY_EN
         r_locked    <= '0;
`endif
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
`ifdef OC_AUTO_RETRY_EN
            r_retry[i] <= w_retry_nxt[i];
            r_idle[i]  <= w_idle_nxt[i];
`endif
         end
         en          <= LINKED ? {N_CH{~|w_faulted_nxt}} : ~w_faulted_nxt;
         fault       <= w_faulted_nxt;
         overcurrent <= |w_faulted_nxt;
`ifdef OC_AUTO_RETRY_EN
         r_locked    <= w_locked_nxt;
`endif
      end
   end

`ifdef OC_AUTO_RETRY_EN
   assign locked = r_locked;
`else
   assign locked = '0;
`endif

endmodule

// File: tb/tb_oc_guard.sv
// Directed bench for oc_guard: one per-channel unit (LINKED=0) and one linked unit (LINKED=1).
`timescale 1ns/1ps
module tb_oc_guard;

   localparam int QC = 16;
   localparam int RC = 32;
   localparam int MR = 2;

   logic       clk;
   logic       rst0, rst1;
   logic [1:0] oc_n0, clr0, en0, fault0, locked0;
   logic [1:0] oc_n1, clr1, en1, fault1, locked1;
   logic       ovc0, ovc1;
   wire  [6:0] obs0 = {en0, fault0, locked0, ovc0};
   wire  [6:0] obs1 = {en1, fault1, locked1, ovc1};

   int n_vec = 0;
   int n_err = 0;
   int edge_n = 0;

   oc_guard #(.N_CH(2), .QUAL_CYCLES(QC), .RETRY_CYCLES(RC), .MAX_RETRIES(MR), .LINKED(1'b0)) dut0 (
      .CLK100MHZ(clk), .RST(rst0), .oc_n(oc_n0), .clr(clr0),
      .en(en0), .fault(fault0), .locked(locked0), .overcurrent(ovc0));

   oc_guard #(.N_CH(2), .QUAL_CYCLES(QC), .RETRY_CYCLES(RC), .MAX_RETRIES(MR), .LINKED(1'b1)) dut1 (
      .CLK100MHZ(clk), .RST(rst1), .oc_n(oc_n1), .clr(clr1),
      .en(en1), .fault(fault1), .locked(locked1), .overcurrent(ovc1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // Vectors are {en[1:0], fault[1:0], locked[1:0], overcurrent}.
   task automatic test_reset();
      rst0 = 1'b1; rst1 = 1'b1;
      oc_n0 = 2'b11; oc_n1 = 2'b11; clr0 = 2'b00; clr1 = 2'b00;
      tick(); tick();
      n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL reset_hold_dut0: got %b want %b", obs0, 7'b1100000); end
      n_vec++; if (obs1 !== 7'b1100000) begin n_err++; $display("FAIL reset_hold_dut1: got %b want %b", obs1, 7'b1100000); end
      rst0 = 1'b0; rst1 = 1'b0;
      repeat (4) tick();
      n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL reset_idle_dut0: got %b want %b", obs0, 7'b1100000); end
      n_vec++; if (obs1 !== 7'b1100000) begin n_err++; $display("FAIL reset_idle_dut1: got %b want %b", obs1, 7'b1100000); end
   endtask

   task automatic test_no_trip();
      oc_n0[0] = 1'b0;
      edge_n = 0;
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (e == 10) oc_n0[0] = 1'b1;
         n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL no_trip edge %0d: got %b want %b", e, obs0, 7'b1100000); end
      end
   endtask

   task automatic test_trip();
      logic [6:0] exp;
      oc_n0[0] = 1'b0;
      edge_n = 0;
      for (int e = 1; e <= QC + 3; e++) begin
         tick();
         exp = (e < QC + 3) ? 7'b1100000 : 7'b1001001;
         n_vec++; if (obs0 !== exp) begin n_err++; $display("FAIL trip edge %0d: got %b want %b", e, obs0, exp); end
      end
   endtask

`ifndef OC_AUTO_RETRY_EN
   task automatic test_latch();
      for (int c = 0; c < 200; c++) begin
         tick();
         n_vec++; if (obs0 !== 7'b1001001) begin n_err++; $display("FAIL latch cycle %0d: got %b want %b", c, obs0, 7'b1001001); end
      end
   endtask

   task automatic test_clr();
      clr0[0] = 1'b1;
      tick();
      clr0[0] = 1'b0;
      n_vec++; if (obs0 !== 7'b1001001) begin n_err++; $display("FAIL clr_while_asserted: got %b want %b", obs0, 7'b1001001); end
      oc_n0[0] = 1'b1;
      repeat (3) tick();
      n_vec++; if (obs0 !== 7'b1001001) begin n_err++; $display("FAIL still_latched: got %b want %b", obs0, 7'b1001001); end
      clr0[0] = 1'b1;
      tick();
      clr0[0] = 1'b0;
      n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL clr_release: got %b want %b", obs0, 7'b1100000); end
      tick();
      n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL after_clr: got %b want %b", obs0, 7'b1100000); end
   endtask
`else
   // Trip 1 at edge 19 -> COOL 20 -> IDLE 52 -> QUAL 53 -> trip 2 at 69 -> COOL 70 -> IDLE 102 -> trip 3 locks at 119.
   task automatic test_retry();
      logic [6:0] exp;
      for (int e = QC + 4; e <= 160; e++) begin
         tick();
         if ((e >= 52 && e <= 68) || (e >= 102 && e <= 118)) exp = 7'b1100000;
         else if (e >= 119)                                   exp = 7'b1001011;
         else                                                  exp = 7'b1001001;
         n_vec++; if (obs0 !== exp) begin n_err++; $display("FAIL retry edge %0d: got %b want %b", e, obs0, exp); end
      end
      oc_n0[0] = 1'b1;
      repeat (3) tick();
      clr0[0] = 1'b1;
      tick();
      clr0[0] = 1'b0;
      n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL locked_clr: got %b want %b", obs0, 7'b1100000); end
   endtask
`endif

   // Channel 1 asserted only around QUAL entry and again just before evaluation.
   task automatic test_glitch();
      logic [6:0] exp;
      edge_n = 0;
      for (int e = 1; e <= QC + 3; e++) begin
         oc_n0[1] = (e == 1 || e == QC + 1) ? 1'b0 : 1'b1;
         tick();
         exp = (e < QC + 3) ? 7'b1100000 : 7'b0110001;
         n_vec++; if (obs0 !== exp) begin n_err++; $display("FAIL glitch edge %0d: got %b want %b", e, obs0, exp); end
      end
      oc_n0[1] = 1'b1;
      repeat (3) tick();
`ifndef OC_AUTO_RETRY_EN
      n_vec++; if (obs0 !== 7'b0110001) begin n_err++; $display("FAIL glitch_latched: got %b want %b", obs0, 7'b0110001); end
      clr0[1] = 1'b1;
      tick();
      clr0[1] = 1'b0;
      n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL glitch_clr: got %b want %b", obs0, 7'b1100000); end
`else
      clr0[1] = 1'b1;
      tick();
      clr0[1] = 1'b0;
      n_vec++; if (obs0 !== 7'b0110001) begin n_err++; $display("FAIL glitch_cool: got %b want %b", obs0, 7'b0110001); end
      while (edge_n < 51) tick();
      n_vec++; if (obs0 !== 7'b0110001) begin n_err++; $display("FAIL glitch_cool_end: got %b want %b", obs0, 7'b0110001); end
      tick();
      n_vec++; if (obs0 !== 7'b1100000) begin n_err++; $display("FAIL glitch_reenable: got %b want %b", obs0, 7'b1100000); end
`endif
   endtask

   task automatic test_linked();
      logic [6:0] exp;
      oc_n1[1] = 1'b0;
      edge_n = 0;
      for (int e = 1; e <= QC + 3; e++) begin
         tick();
         exp = (e < QC + 3) ? 7'b1100000 : 7'b0010001;
         n_vec++; if (obs1 !== exp) begin n_err++; $display("FAIL linked edge %0d: got %b want %b", e, obs1, exp); end
      end
      rst1 = 1'b1;
      #1;
      n_vec++; if (obs1 !== 7'b1100000) begin n_err++; $display("FAIL async_rst_trip: got %b want %b", obs1, 7'b1100000); end
      tick();
      rst1 = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         n_vec++; if (obs1 !== 7'b1100000) begin n_err++; $display("FAIL requal edge %0d: got %b want %b", e, obs1, 7'b1100000); end
      end
      rst1 = 1'b1;
      #1;
      n_vec++; if (obs1 !== 7'b1100000) begin n_err++; $display("FAIL async_rst_qual: got %b want %b", obs1, 7'b1100000); end
      tick();
      rst1 = 1'b0;
      // A reset mid-window must restart qualification from scratch.
      for (int e = 1; e <= QC + 3; e++) begin
         tick();
         exp = (e < QC + 3) ? 7'b1100000 : 7'b0010001;
         n_vec++; if (obs1 !== exp) begin n_err++; $display("FAIL post_rst edge %0d: got %b want %b", e, obs1, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_no_trip();
      test_trip();
`ifndef OC_AUTO_RETRY_EN
      test_latch();
      test_clr();
`else
      test_retry();
`endif
      test_glitch();
      test_linked();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
